sa_tile_sched: RTL and testbench

SA_TILE_SCHED -- requirements
Module: sa_tile_sched

---
 rtl/sa_tile_sched.sv | 201 ++++++++++++++++++++
 tb/tb_sa_tile_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_sched.sv
// Tiled-GEMM scheduler for a systolic array: walks output tiles (m, n) and
// reduction tiles k, accumulates SA partial tiles and emits saturated output tiles.
module sa_tile_sched #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int MAX_T = 16,
    parameter int ACC_W = 24,
    parameter int FRAC  = 0
) (
    input  logic                          I_CLK,
    input  logic                          I_SYNC_RST,
    input  logic                          I_START,
    input  logic [$clog2(MAX_T+1)-1:0]    I_M_TILES,
    input  logic [$clog2(MAX_T+1)-1:0]    I_N_TILES,
    input  logic [$clog2(MAX_T+1)-1:0]    I_K_TILES,
    output logic                          O_SA_START,
    output logic [$clog2(MAX_T)-1:0]      O_TILE_M,
    output logic [$clog2(MAX_T)-1:0]      O_TILE_N,
    output logic [$clog2(MAX_T)-1:0]      O_TILE_K,
    input  logic                          I_SA_VLD,
    input  logic [SA_R*SA_C*D_W-1:0]      I_SA_RESULT,
    output logic                          O_TILE_VLD,
    input  logic                          I_TILE_RDY,
    output logic [SA_R*SA_C*D_W-1:0]      O_TILE_DATA,
    output logic [$clog2(MAX_T)-1:0]      O_OUT_M,
    output logic [$clog2(MAX_T)-1:0]      O_OUT_N,
    output logic                          O_BUSY,
    output logic                          O_DONE
);

    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam int IDX_W = $clog2(MAX_T);
    localparam int NEL   = SA_R * SA_C;
    localparam logic [CNT_W-1:0]        MAX_CNT = CNT_W'(MAX_T);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] m_cnt_q, n_cnt_q, k_cnt_q;
    logic [IDX_W-1:0] m_q, n_q, k_q;
    logic [IDX_W-1:0] out_m_q, out_n_q;
    logic             sa_start_q, tile_vld_q, busy_q, done_q;

    logic start_ok;
    logic last_m, last_n, last_k;
    logic acc_en, acc_load;

    assign start_ok = (I_M_TILES != '0) && (I_M_TILES <= MAX_CNT) &&
                      (I_N_TILES != '0) && (I_N_TILES <= MAX_CNT) &&
                      (I_K_TILES != '0) && (I_K_TILES <= MAX_CNT);

    assign last_m = (CNT_W'(m_q) == m_cnt_q - CNT_W'(1));
    assign last_n = (CNT_W'(n_q) == n_cnt_q - CNT_W'(1));
    assign last_k = (CNT_W'(k_q) == k_cnt_q - CNT_W'(1));

    // The first reduction tile overwrites the accumulator, later ones add to it.
    assign acc_en   = (state_q == S_WAIT) && I_SA_VLD;
    assign acc_load = (k_q == '0);

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_q    <= S_IDLE;
            m_cnt_q    <= '0;
            n_cnt_q    <= '0;
            k_cnt_q    <= '0;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            out_m_q    <= '0;
            out_n_q    <= '0;
            sa_start_q <= 1'b0;
            tile_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sa_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (I_START) begin
                        busy_q <= 1'b1;
                        if (start_ok) begin
                            m_cnt_q    <= I_M_TILES;
                            n_cnt_q    <= I_N_TILES;
                            k_cnt_q    <= I_K_TILES;
                            m_q        <= '0;
                            n_q        <= '0;
                            k_q        <= '0;
                            sa_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (I_SA_VLD) begin
                        if (last_k) begin
                            tile_vld_q <= 1'b1;
                            out_m_q    <= m_q;
                            out_n_q    <= n_q;
                            state_q    <= S_OUT;
                        end else begin
                            k_q        <= k_q + IDX_W'(1);
                            sa_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (I_TILE_RDY) begin
                        tile_vld_q <= 1'b0;
                        k_q        <= '0;
                        if (!last_n) begin
                            n_q        <= n_q + IDX_W'(1);
                            sa_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else if (!last_m) begin
                            n_q        <= '0;
                            m_q        <= m_q + IDX_W'(1);
                            sa_start_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            n_q     <= '0;
                            m_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Per-element accumulate, rescale and saturate. The output is a pure
    // function of the accumulator, so it is zero after reset and frozen in OUT.
    for (genvar gi = 0; gi < NEL; gi++) begin : g_el
        logic signed [D_W-1:0]   el_in;
        logic signed [ACC_W-1:0] el_ext;
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_d;
        logic signed [ACC_W-1:0] acc_shr;
        logic        [D_W-1:0]   sat_el;

        assign el_in   = I_SA_RESULT[gi*D_W +: D_W];
        assign el_ext  = {{(ACC_W - D_W){el_in[D_W-1]}}, el_in};
        assign acc_d   = acc_load ? el_ext : (acc_q + el_ext);
        assign acc_shr = acc_q >>> FRAC;

        always_ff @(posedge I_CLK) begin
            if (I_SYNC_RST) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_d;
            end
        end

        always_comb begin
            sat_el = acc_shr[D_W-1:0];
            if (acc_shr > SAT_MAX) begin
                sat_el = SAT_MAX[D_W-1:0];
            end else if (acc_shr < SAT_MIN) begin
                sat_el = SAT_MIN[D_W-1:0];
            end
        end

        assign O_TILE_DATA[gi*D_W +: D_W] = sat_el;
    end

    assign O_SA_START = sa_start_q;
    assign O_TILE_M   = m_q;
    assign O_TILE_N   = n_q;
    assign O_TILE_K   = k_q;
    assign O_TILE_VLD = tile_vld_q;
    assign O_OUT_M    = out_m_q;
    assign O_OUT_N    = out_n_q;
    assign O_BUSY     = busy_q;
    assign O_DONE     = done_q;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Bench for sa_tile_sched: two instances (FRAC=0 and FRAC=1) share stimulus and
// are compared against a tile-level sum/shift/clamp reference model.
`timescale 1ns/1ps
module tb_sa_tile_sched;

    localparam int D_W   = 8;
    localparam int SA_R  = 2;
    localparam int SA_C  = 2;
    localparam int MAX_T = 4;
    localparam int ACC_W = 16;
    localparam int NEL   = SA_R * SA_C;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam int IW    = $clog2(MAX_T);
    localparam int DW    = NEL * D_W;

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic [CW-1:0] m_t, n_t, k_t;
    logic          sa_vld;
    logic [DW-1:0] sa_res;
    logic          tile_rdy;

    logic          sa_start0, tile_vld0, busy0, done0;
    logic [IW-1:0] tm0, tn0, tk0, om0, on0;
    logic [DW-1:0] data0;
    logic          sa_start1, tile_vld1, busy1, done1;
    logic [IW-1:0] tm1, tn1, tk1, om1, on1;
    logic [DW-1:0] data1;

    int n_chk  = 0;
    int n_pass = 0;
    int res_tbl [MAX_T][MAX_T][MAX_T][NEL];

    always #5 clk = ~clk;

    sa_tile_sched #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .MAX_T(MAX_T),
                    .ACC_W(ACC_W), .FRAC(0)) dut0 (
        .I_CLK(clk), .I_SYNC_RST(srst), .I_START(start),
        .I_M_TILES(m_t), .I_N_TILES(n_t), .I_K_TILES(k_t),
        .O_SA_START(sa_start0), .O_TILE_M(tm0), .O_TILE_N(tn0), .O_TILE_K(tk0),
        .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_res),
        .O_TILE_VLD(tile_vld0), .I_TILE_RDY(tile_rdy), .O_TILE_DATA(data0),
        .O_OUT_M(om0), .O_OUT_N(on0), .O_BUSY(busy0), .O_DONE(done0)
    );

    sa_tile_sched #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .MAX_T(MAX_T),
                    .ACC_W(ACC_W), .FRAC(1)) dut1 (
        .I_CLK(clk), .I_SYNC_RST(srst), .I_START(start),
        .I_M_TILES(m_t), .I_N_TILES(n_t), .I_K_TILES(k_t),
        .O_SA_START(sa_start1), .O_TILE_M(tm1), .O_TILE_N(tn1), .O_TILE_K(tk1),
        .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_res),
        .O_TILE_VLD(tile_vld1), .I_TILE_RDY(tile_rdy), .O_TILE_DATA(data1),
        .O_OUT_M(om1), .O_OUT_N(on1), .O_BUSY(busy1), .O_DONE(done1)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: output tile = clamp(sum over k of SA partials, shifted by frac).
    function automatic logic [DW-1:0] exp_tile(int m, int n, int kk, int frac);
        logic [DW-1:0] v;
        int s;
        v = '0;
        for (int e = 0; e < NEL; e++) begin
            s = 0;
            for (int k = 0; k < kk; k++) s += res_tbl[m][n][k][e];
            s = s >>> frac;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            v[e*D_W +: D_W] = 8'(s);
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] pack_res(int m, int n, int k);
        logic [DW-1:0] v;
        for (int e = 0; e < NEL; e++) v[e*D_W +: D_W] = 8'(res_tbl[m][n][k][e]);
        return v;
    endfunction

    task automatic fill_const(int m, int n, int k, int val);
        for (int e = 0; e < NEL; e++) res_tbl[m][n][k][e] = val;
    endtask

    task automatic fill_rand(int M, int N, int K);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++)
                    for (int e = 0; e < NEL; e++)
                        res_tbl[m][n][k][e] = int'($urandom_range(255)) - 128;
    endtask

    // Acts as SA and consumer for one full job, checking every handshake.
    task automatic run_job(int M, int N, int K, int stall, bit noise);
        int t;
        logic [DW-1:0] e0, e1;
        m_t = CW'(M); n_t = CW'(N); k_t = CW'(K);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                for (int k = 0; k < K; k++) begin
                    t = 0;
                    while (!sa_start0 && t < 30) begin tick(); t++; end
                    chk("sa_start", {sa_start1, sa_start0}, 2'b11);
                    chk("tile_idx", {tm0, tn0, tk0}, m*16 + n*4 + k);
                    chk("tile_idx_f1", {tm1, tn1, tk1}, m*16 + n*4 + k);
                    tick();
                    chk("sa_start_1cyc", sa_start0, 0);
                    if (noise && $urandom_range(1) == 1) begin
                        m_t = 3'd1; n_t = 3'd1; k_t = 3'd1;
                        start = 1'b1;
                        tick();
                        start = 1'b0;
                    end
                    repeat ($urandom_range(2)) tick();
                    sa_res = pack_res(m, n, k);
                    sa_vld = 1'b1;
                    tick();
                    sa_vld = 1'b0;
                    sa_res = DW'($urandom);
                end
                e0 = exp_tile(m, n, K, 0);
                e1 = exp_tile(m, n, K, 1);
                chk("tile_vld", {tile_vld1, tile_vld0}, 2'b11);
                chk("tile_data", data0, e0);
                chk("tile_data_f1", data1, e1);
                chk("out_mn", {om0, on0}, m*4 + n);
                for (int s = 0; s < stall; s++) begin
                    if (noise && s == 1) sa_vld = 1'b1;
                    tick();
                    sa_vld = 1'b0;
                    chk("stall_vld", tile_vld0, 1);
                    chk("stall_data", data0, e0);
                    chk("stall_data_f1", data1, e1);
                    chk("stall_mn", {om0, on0}, m*4 + n);
                end
                tile_rdy = 1'b1;
                tick();
                tile_rdy = 1'b0;
                chk("tile_vld_drop", tile_vld0, 0);
            end
        end
        chk("done", {done1, done0}, 2'b11);
        chk("busy_in_done", busy0, 1);
        tick();
        chk("done_pulse", done0, 0);
        chk("busy_end", busy0, 0);
        $display("job M=%0d N=%0d K=%0d stall=%0d noise=%0d checks=%0d", M, N, K, stall, noise, n_chk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ctrl"}, {sa_start0, tile_vld0, busy0, done0}, 0);
        chk({tag, "_idx"}, {tm0, tn0, tk0, om0, on0}, 0);
        chk({tag, "_data"}, data0, 0);
        chk({tag, "_data_f1"}, data1, 0);
    endtask

    task automatic bad_start(int M, int N, int K);
        m_t = CW'(M); n_t = CW'(N); k_t = CW'(K);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_done", done0, 1);
        chk("bad_no_sa", sa_start0, 0);
        tick();
        chk("bad_done_pulse", done0, 0);
        chk("bad_no_sa2", sa_start0, 0);
        chk("bad_idle", busy0, 0);
        $display("bad start M=%0d N=%0d K=%0d checks=%0d", M, N, K, n_chk);
    endtask

    initial begin
        int any_done;
        srst = 1'b1; start = 1'b0; m_t = '0; n_t = '0; k_t = '0;
        sa_vld = 1'b0; sa_res = '0; tile_rdy = 1'b0;
        repeat (3) tick();
        reset_checks("rst");
        srst = 1'b0;
        tick();

        // Single tile, all elements 3
        fill_const(0, 0, 0, 3);
        run_job(1, 1, 1, 0, 0);

        // Saturation high, saturation low, and the rescaled 100+50 case
        fill_const(0, 0, 0, 100);  fill_const(0, 0, 1, 100);
        run_job(1, 1, 2, 1, 0);
        fill_const(0, 0, 0, -100); fill_const(0, 0, 1, -100);
        run_job(1, 1, 2, 0, 0);
        fill_const(0, 0, 0, 100);  fill_const(0, 0, 1, 50);
        run_job(1, 1, 2, 0, 0);

        // Multi-tile walk with a 5-cycle consumer stall and spurious activity
        fill_rand(2, 3, 1);
        run_job(2, 3, 1, 5, 1);

        for (int i = 0; i < 6; i++) begin
            int M, N, K;
            M = int'($urandom_range(3)) + 1;
            N = int'($urandom_range(3)) + 1;
            K = int'($urandom_range(3)) + 1;
            fill_rand(M, N, K);
            run_job(M, N, K, int'($urandom_range(3)), 1);
        end

        bad_start(1, 1, 0);
        bad_start(0, 2, 2);
        bad_start(5, 1, 1);

        // Reset while waiting on the SA
        fill_rand(2, 2, 2);
        m_t = 3'd2; n_t = 3'd2; k_t = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr_sa_start", sa_start0, 1);
        tick();
        srst = 1'b1;
        tick();
        reset_checks("wait_rst");
        srst = 1'b0;
        any_done = 0;
        repeat (6) begin
            tick();
            if (done0 || busy0 || sa_start0) any_done = 1;
        end
        chk("wait_rst_quiet", any_done, 0);
        $display("reset in WAIT checks=%0d", n_chk);

        // Reset wins over a simultaneous start
        m_t = 3'd1; n_t = 3'd1; k_t = 3'd1;
        srst = 1'b1; start = 1'b1;
        tick();
        srst = 1'b0; start = 1'b0;
        tick();
        chk("rst_prio", {busy0, sa_start0}, 0);
        $display("reset priority checks=%0d", n_chk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
